if_pc_gen: RTL

- Fetch-address generator and request sequencer, directly upstream of the IFU.
- Holds the architectural fetch PC and issues one instruction-fetch request at a time to the I-side memory/icache port.
- Delivers {pc, 32-bit word, valid} to the IFU, which consumes them as inst_addr_i / if_rdata_i / if_rdata_valid_i.
- Selects the next PC by priority: EX redirect/flush, then BPU prediction, then sequential PC + 2/4. Drops responses made stale by a redirect.

---
 rtl/if_pc_gen_pkg.sv | 11 +
 rtl/if_pc_gen_next_pc_sel.sv | 16 +
 rtl/if_pc_gen.sv | 89 ++++++++
 3 files changed

// File: rtl/if_pc_gen_pkg.sv
// if_pc_gen_pkg: shared widths, constants and FSM encodings for the fetch-address generator
package if_pc_gen_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] IPG_INST_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] IPG_RESET_PC = 32'h3000_0000;
  typedef enum logic [1:0] {
    IPG_REQ  = 2'd0,
    IPG_WAIT = 2'd1,
    IPG_HOLD = 2'd2
  } ipg_state_e;
endpackage

// File: rtl/if_pc_gen_next_pc_sel.sv
// if_pc_gen_next_pc_sel: next fetch PC priority mux (redirect > prediction > sequential +2/+4)
module if_pc_gen_next_pc_sel
  import if_pc_gen_pkg::*;
(
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            bpu_valid,
  input  logic [XLEN-1:0] bpu_pc,
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      inst_lo,
  output logic [XLEN-1:0] next_pc
);
  logic [XLEN-1:0] seq_pc;
  assign seq_pc  = pc + (inst_lo == 2'b11 ? XLEN'(4) : XLEN'(2));
  assign next_pc = redirect_valid ? redirect_pc : bpu_valid ? bpu_pc : seq_pc;
endmodule

// File: rtl/if_pc_gen.sv
// if_pc_gen: fetch PC holder and single-outstanding I-side request sequencer feeding the IFU
module if_pc_gen
  import if_pc_gen_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = IPG_RESET_PC,
  parameter logic [XLEN-1:0] INST_NOP = IPG_INST_NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            bpu_pc_valid_i,
  input  logic [XLEN-1:0] bpu_pc_i,
  input  logic            stall_i,
  output logic            req_valid_o,
  output logic [XLEN-1:0] req_addr_o,
  input  logic            req_ready_i,
  input  logic            resp_valid_i,
  input  logic [XLEN-1:0] resp_data_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_inst_o,
  output logic            outstanding_o
);
  ipg_state_e state;
  logic [XLEN-1:0] pc_q, next_pc;
  logic drop_q, pc_upd;
  assign pc_upd     = redirect_valid_i || (if_valid_o && !stall_i);
  assign req_addr_o = pc_q;
  if_pc_gen_next_pc_sel u_sel (
    .redirect_valid(redirect_valid_i),
    .redirect_pc   (redirect_pc_i),
    .bpu_valid     (bpu_pc_valid_i),
    .bpu_pc        (bpu_pc_i),
    .pc            (pc_q),
    .inst_lo       (if_inst_o[1:0]),
    .next_pc       (next_pc)
  );
  // request/response/hold sequencing; a redirect retargets pc_q and poisons any in-flight response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IPG_REQ;
      pc_q          <= RESET_PC;
      req_valid_o   <= 1'b0;
      if_valid_o    <= 1'b0;
      if_pc_o       <= RESET_PC;
      if_inst_o     <= INST_NOP;
      outstanding_o <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      if (pc_upd) pc_q <= next_pc;
      case (state)
        IPG_REQ:
          if (req_valid_o && req_ready_i) begin
            state         <= IPG_WAIT;
            req_valid_o   <= 1'b0;
            outstanding_o <= 1'b1;
            drop_q        <= redirect_valid_i;
          end else begin
            req_valid_o <= 1'b1;
          end
        IPG_WAIT:
          if (resp_valid_i) begin
            outstanding_o <= 1'b0;
            drop_q        <= 1'b0;
            if (drop_q || redirect_valid_i) begin
              state       <= IPG_REQ;
              req_valid_o <= 1'b1;
            end else begin
              state      <= IPG_HOLD;
              if_valid_o <= 1'b1;
              if_pc_o    <= pc_q;
              if_inst_o  <= resp_data_i;
            end
          end else if (redirect_valid_i) begin
            drop_q <= 1'b1;
          end
        IPG_HOLD:
          if (redirect_valid_i || !stall_i) begin
            state       <= IPG_REQ;
            req_valid_o <= 1'b1;
            if_valid_o  <= 1'b0;
            if_inst_o   <= INST_NOP;
          end
        default: state <= IPG_REQ;
      endcase
    end
  end
endmodule
